// File: rtl/ahb_access_seq_pkg.sv
// Shared encodings for the JTAG-to-AHB access sequencer.
// Command layout, states, sizes and status bit positions.
package ahb_access_seq_pkg;

   typedef enum logic [1:0] {
      OP_NOP     = 2'b00,
      OP_SETADDR = 2'b01,
      OP_WRITE   = 2'b10,
      OP_READ    = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_BAD  = 2'b11
   } size_e;

   typedef struct packed {
      op_e         op;
      size_e       size;
      logic        clr;
      logic        rsvd;
      logic [31:0] payload;
   } cmd_t;

   localparam int CMD_W    = 38;
   localparam int STS_BUSY = 37;
   localparam int STS_ERR  = 36;
   localparam int STS_TO   = 35;
   localparam int STS_OVR  = 34;

   function automatic logic [31:0] size_bytes(input logic [1:0] s);
      unique case (s)
         SZ_BYTE: size_bytes = 32'd1;
         SZ_HALF: size_bytes = 32'd2;
         default: size_bytes = 32'd4;
      endcase
   endfunction

endpackage

// File: rtl/ahb_access_seq_if.sv
// TAP data-register side and AHB-lite bus side of the sequencer.
interface ahb_access_seq_if;
   import ahb_access_seq_pkg::*;

   logic              ahb_select;
   logic              dr_capture;
   logic              dr_update;
   logic [CMD_W-1:0]  cmd_in;
   logic [CMD_W-1:0]  status_out;
   logic              bus_req;
   logic              bus_write;
   logic [31:0]       bus_addr;
   logic [1:0]        bus_size;
   logic [31:0]       bus_wdata;
   logic              bus_ack;
   logic              bus_err;
   logic [31:0]       bus_rdata;
   logic              busy;

   modport master (
      input  ahb_select, dr_capture, dr_update, cmd_in,
      input  bus_ack, bus_err, bus_rdata,
      output status_out, bus_req, bus_write, bus_addr,
      output bus_size, bus_wdata, busy
   );

   modport slave (
      output ahb_select, dr_capture, dr_update, cmd_in,
      output bus_ack, bus_err, bus_rdata,
      input  status_out, bus_req, bus_write, bus_addr,
      input  bus_size, bus_wdata, busy
   );

endinterface

// File: rtl/ahb_seq_timer.sv
// Counts cycles spent waiting on the bus; expires on the LIMIT-th cycle.
module ahb_seq_timer #(
   parameter logic [7:0] LIMIT = 8'd200
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_start,
   input  logic i_clear,
   output logic o_expired
);

   logic [7:0] r_cnt;
   logic [8:0] w_next;

   assign w_next    = {1'b0, r_cnt} + 9'd1;
   assign o_expired = i_start && (w_next >= {1'b0, LIMIT});

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= 8'd0;
      end else if (i_clear) begin
         r_cnt <= 8'd0;
      end else if (i_start && !o_expired) begin
         r_cnt <= w_next[7:0];
      end
   end

endmodule

// File: rtl/ahb_access_seq.sv
// TAP-driven single-transfer AHB sequencer with sticky status flags.
// Optional AHB_ACCESS_SEQ_AUTOINC_EN: post-increment address on good transfers.
module ahb_access_seq
   import ahb_access_seq_pkg::*;
#(
   parameter logic [7:0] TIMEOUT_CYCLES = 8'd200
) (
   input  logic             TCK,
   input  logic             TRST,
   ahb_access_seq_if.master p
);

   state_e      r_state;
   logic        r_req;
   logic        r_write;
   logic [31:0] r_addr;
   logic [1:0]  r_size;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic        r_err;
   logic        r_to;
   logic        r_ovr;
   logic [CMD_W-1:0] r_status;

   cmd_t        w_cmd;
   logic        w_acc;
   logic        w_in_req;
   logic        w_expired;
   logic        w_busy;
   logic        w_unused;
   logic [CMD_W-1:0] w_status;

   assign w_cmd    = cmd_t'(p.cmd_in);
   assign w_acc    = p.ahb_select & p.dr_update;
   assign w_in_req = (r_state == ST_REQ);
   assign w_busy   = (r_state != ST_IDLE);
   assign w_unused = w_cmd.rsvd;

   ahb_seq_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timer (
      .i_clk     (TCK),
      .i_rst     (TRST),
      .i_start   (w_in_req),
      .i_clear   (!w_in_req),
      .o_expired (w_expired)
   );

   always_comb begin
      w_status           = '0;
      w_status[STS_BUSY] = w_busy;
      w_status[STS_ERR]  = r_err;
      w_status[STS_TO]   = r_to;
      w_status[STS_OVR]  = r_ovr;
      w_status[31:0]     = r_rdata;
   end

   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         r_state  <= ST_IDLE;
         r_req    <= 1'b0;
         r_write  <= 1'b0;
         r_addr   <= 32'd0;
         r_size   <= SZ_WORD;
         r_wdata  <= 32'd0;
         r_rdata  <= 32'd0;
         r_err    <= 1'b0;
         r_to     <= 1'b0;
         r_ovr    <= 1'b0;
         r_status <= '0;
      end else begin
         if (p.ahb_select && p.dr_capture) begin
            r_status <= w_status;
         end
         // Clear first; any flag set below in the same cycle wins.
         if (w_acc && w_cmd.clr) begin
            r_err <= 1'b0;
            r_to  <= 1'b0;
            r_ovr <= 1'b0;
         end
         unique case (r_state)
            ST_IDLE: begin
               if (w_acc) begin
                  unique case (w_cmd.op)
                     OP_SETADDR: r_addr <= w_cmd.payload;
                     OP_WRITE, OP_READ: begin
                        if (w_cmd.size == SZ_BAD) begin
                           r_err <= 1'b1;
                        end else begin
                           r_req   <= 1'b1;
                           r_write <= (w_cmd.op == OP_WRITE);
                           r_size  <= w_cmd.size;
                           r_state <= ST_REQ;
                           if (w_cmd.op == OP_WRITE) begin
                              r_wdata <= w_cmd.payload;
                           end
                        end
                     end
                     OP_NOP: ;
                  endcase
               end
            end
            ST_REQ: begin
               if (w_acc) begin
                  r_ovr <= 1'b1;
               end
               // bus_err outranks ack, ack outranks the timeout.
               priority case (1'b1)
                  p.bus_err: begin
                     r_err   <= 1'b1;
                     r_req   <= 1'b0;
                     r_state <= ST_DONE;
                  end
                  p.bus_ack: begin
                     r_req   <= 1'b0;
                     r_state <= ST_DONE;
                     if (!r_write) begin
                        r_rdata <= p.bus_rdata;
                     end
`ifdef AHB_ACCESS_SEQ_AUTOINC_EN
                     r_addr <= r_addr + size_bytes(r_size);
`endif
                  end
                  w_expired: begin
                     r_to    <= 1'b1;
                     r_req   <= 1'b0;
                     r_state <= ST_DONE;
                  end
                  default: ;
               endcase
            end
            ST_DONE: begin
               if (w_acc) begin
                  r_ovr <= 1'b1;
               end
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign p.bus_req    = r_req;
   assign p.bus_write  = r_write;
   assign p.bus_addr   = r_addr;
   assign p.bus_size   = r_size;
   assign p.bus_wdata  = r_wdata;
   assign p.busy       = w_busy;
   assign p.status_out = r_status;

endmodule

// File: tb/tb_ahb_access_seq.sv
// Directed scoreboard bench for ahb_access_seq (TIMEOUT_CYCLES = 4).
module tb_ahb_access_seq;
   import ahb_access_seq_pkg::*;

`ifdef AHB_ACCESS_SEQ_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   typedef struct packed {
      logic        wr;
      logic [1:0]  sz;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [7:0]  len;
   } xfer_t;

   logic TCK  = 1'b0;
   logic TRST = 1'b1;
   always #5 TCK = ~TCK;

   ahb_access_seq_if ifc();

   ahb_access_seq #(
      .TIMEOUT_CYCLES (8'd4)
   ) dut (
      .TCK  (TCK),
      .TRST (TRST),
      .p    (ifc.master)
   );

   xfer_t       q_x[$];
   logic [37:0] q_s[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_addr;
   logic [31:0] exp_wd;

   task automatic chk(input string nm, input logic [79:0] act,
                      input logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [37:0] st(input logic b, input logic e,
                                      input logic t, input logic o,
                                      input logic [31:0] rd);
      return {b, e, t, o, 2'b00, rd};
   endfunction

   function automatic logic [31:0] bump(input logic [31:0] a,
                                        input logic [31:0] b);
      return AUTOINC ? a + b : a;
   endfunction

   // Monitor: compares status captures and every bus_req cycle.
   logic        cap_seen = 1'b0;
   logic        prev_req = 1'b0;
   logic [7:0]  len_cnt  = 8'd0;
   xfer_t       cur;

   always @(posedge TCK) cap_seen <= ifc.ahb_select & ifc.dr_capture;

   always @(negedge TCK) begin
      if (cap_seen) begin
         if (q_s.size() == 0) begin
            chk("status_unexpected", 80'(ifc.status_out), 80'hx);
         end else begin
            chk("status", 80'(ifc.status_out), 80'(q_s.pop_front()));
         end
      end
      if (ifc.bus_req) begin
         if (!prev_req) begin
            if (q_x.size() == 0) begin
               chk("xfer_unexpected", 80'(ifc.bus_addr), 80'hx);
               cur = '0;
            end else begin
               cur = q_x.pop_front();
            end
            len_cnt = 8'd1;
         end else begin
            len_cnt = len_cnt + 8'd1;
         end
         chk("bus_hold",
             80'({ifc.bus_write, ifc.bus_size, ifc.bus_addr, ifc.bus_wdata}),
             80'({cur.wr, cur.sz, cur.addr, cur.wd}));
      end else if (prev_req) begin
         chk("req_len", 80'(len_cnt), 80'(cur.len));
      end
      prev_req = ifc.bus_req;
   end

   task automatic cmd(input logic [1:0] op, input logic [1:0] sz,
                      input logic clr, input logic [31:0] pl);
      ifc.ahb_select = 1'b1;
      ifc.cmd_in     = {op, sz, clr, 1'b0, pl};
      ifc.dr_update  = 1'b1;
      @(negedge TCK);
      ifc.dr_update  = 1'b0;
   endtask

   task automatic cap(input logic [37:0] exp);
      q_s.push_back(exp);
      ifc.ahb_select = 1'b1;
      ifc.dr_capture = 1'b1;
      @(negedge TCK);
      ifc.dr_capture = 1'b0;
   endtask

   task automatic ack(input int n, input logic e, input logic [31:0] rd);
      repeat (n - 1) @(negedge TCK);
      ifc.bus_ack   = !e;
      ifc.bus_err   = e;
      ifc.bus_rdata = rd;
      @(negedge TCK);
      ifc.bus_ack   = 1'b0;
      ifc.bus_err   = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (ifc.busy && k < 20) begin
         @(negedge TCK);
         k++;
      end
      chk("idle_wait", 80'(ifc.busy), 80'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ifc.ahb_select = 1'b0;
      ifc.dr_capture = 1'b0;
      ifc.dr_update  = 1'b0;
      ifc.cmd_in     = '0;
      ifc.bus_ack    = 1'b0;
      ifc.bus_err    = 1'b0;
      ifc.bus_rdata  = '0;
      exp_addr       = 32'd0;
      exp_wd         = 32'd0;

      #12;
      chk("rst_req",    80'({ifc.bus_req, ifc.busy, ifc.bus_write}), 80'd0);
      chk("rst_addr",   80'(ifc.bus_addr), 80'd0);
      chk("rst_size",   80'(ifc.bus_size), 80'd2);
      chk("rst_wdata",  80'(ifc.bus_wdata), 80'd0);
      chk("rst_status", 80'(ifc.status_out), 80'd0);
      @(negedge TCK);
      TRST = 1'b0;
      @(negedge TCK);

      // SETADDR then a word write acked on the third cycle.
      exp_addr = 32'h2000_0000;
      cmd(OP_SETADDR, 2'b10, 1'b0, exp_addr);
      chk("setaddr_addr", 80'(ifc.bus_addr), 80'(exp_addr));
      chk("setaddr_quiet", 80'({ifc.bus_req, ifc.busy}), 80'd0);
      exp_wd = 32'hDEAD_BEEF;
      q_x.push_back('{1'b1, 2'b10, exp_addr, exp_wd, 8'd3});
      cmd(OP_WRITE, 2'b10, 1'b0, exp_wd);
      ack(3, 1'b0, 32'h0);
      chk("busy_done", 80'(ifc.busy), 80'd1);
      @(negedge TCK);
      chk("busy_idle", 80'(ifc.busy), 80'd0);
      exp_addr = bump(exp_addr, 32'd4);
      cap(st(0, 0, 0, 0, 32'h0));

      // Word read returning data.
      q_x.push_back('{1'b0, 2'b10, exp_addr, exp_wd, 8'd2});
      cmd(OP_READ, 2'b10, 1'b0, 32'hFFFF);
      ack(2, 1'b0, 32'h1234_5678);
      wait_idle();
      exp_addr = bump(exp_addr, 32'd4);
      cap(st(0, 0, 0, 0, 32'h1234_5678));

      // Byte write with no response: times out after four cycles.
      exp_wd = 32'hA5;
      q_x.push_back('{1'b1, 2'b00, exp_addr, exp_wd, 8'd4});
      cmd(OP_WRITE, 2'b00, 1'b0, exp_wd);
      wait_idle();
      cap(st(0, 0, 1, 0, 32'h1234_5678));

      // Overrun: second command while in REQ is dropped.
      q_x.push_back('{1'b0, 2'b01, exp_addr, exp_wd, 8'd2});
      cmd(OP_READ, 2'b01, 1'b0, 32'h0);
      cmd(OP_WRITE, 2'b10, 1'b0, 32'h1111_1111);
      ack(1, 1'b0, 32'h0000_BEEF);
      chk("overrun_wdata", 80'(ifc.bus_wdata), 80'(exp_wd));
      wait_idle();
      exp_addr = bump(exp_addr, 32'd2);
      cap(st(0, 0, 1, 1, 32'h0000_BEEF));
      cmd(OP_NOP, 2'b00, 1'b1, 32'h0);
      cap(st(0, 0, 0, 0, 32'h0000_BEEF));

      // Illegal size with clear: no transfer, err still set.
      cmd(OP_READ, 2'b11, 1'b1, 32'h0);
      chk("illegal_quiet", 80'({ifc.bus_req, ifc.busy}), 80'd0);
      cap(st(0, 1, 0, 0, 32'h0000_BEEF));

      // bus_err on the timeout cycle records err only.
      exp_wd = 32'h77;
      q_x.push_back('{1'b1, 2'b10, exp_addr, exp_wd, 8'd4});
      cmd(OP_WRITE, 2'b10, 1'b1, exp_wd);
      ack(4, 1'b1, 32'h99);
      wait_idle();
      cap(st(0, 1, 0, 0, 32'h0000_BEEF));

      // dr_update without ahb_select is ignored.
      ifc.ahb_select = 1'b0;
      ifc.cmd_in     = {OP_SETADDR, 2'b10, 1'b0, 1'b0, 32'h1234_0000};
      ifc.dr_update  = 1'b1;
      @(negedge TCK);
      ifc.dr_update  = 1'b0;
      chk("ignore_unselected", 80'(ifc.bus_addr), 80'(exp_addr));

      // Half-word reads across the 2^32 wrap.
      exp_addr = 32'hFFFF_FFFC;
      cmd(OP_SETADDR, 2'b10, 1'b0, exp_addr);
      for (int i = 0; i < 3; i++) begin
         q_x.push_back('{1'b0, 2'b01, exp_addr, exp_wd, 8'd1});
         cmd(OP_READ, 2'b01, 1'b0, 32'h0);
         ack(1, 1'b0, 32'(i));
         wait_idle();
         exp_addr = bump(exp_addr, 32'd2);
      end
      chk("wrap_addr", 80'(ifc.bus_addr), 80'(exp_addr));

      // Asynchronous reset in the middle of a transfer.
      q_x.push_back('{1'b1, 2'b10, exp_addr, 32'h55, 8'd2});
      cmd(OP_WRITE, 2'b10, 1'b0, 32'h55);
      @(negedge TCK);
      #2 TRST = 1'b1;
      #1;
      chk("arst_req",    80'({ifc.bus_req, ifc.busy, ifc.bus_write}), 80'd0);
      chk("arst_addr",   80'(ifc.bus_addr), 80'd0);
      chk("arst_size",   80'(ifc.bus_size), 80'd2);
      chk("arst_wdata",  80'(ifc.bus_wdata), 80'd0);
      chk("arst_status", 80'(ifc.status_out), 80'd0);
      @(negedge TCK);
      TRST = 1'b0;
      @(negedge TCK);
      cap(st(0, 0, 0, 0, 32'h0));

      repeat (3) @(negedge TCK);
      chk("xfer_queue_empty", 80'(q_x.size()), 80'd0);
      chk("status_queue_empty", 80'(q_s.size()), 80'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
